// File: rtl/spi_slave.sv
// SPI responder: oversamples sclk/cs_n/mosi in the clk domain and exchanges 8-bit MSB-first
// bytes. Received bytes are offered on rx_*, and response bytes are taken from tx_*.
`timescale 1ns/1ps

module spi_slave #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter logic [7:0]  TX_IDLE     = 8'hFF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spi_sclk,
   input  logic       spi_cs_n,
   input  logic       spi_mosi,
   output logic       spi_miso,
   output logic       spi_miso_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       tx_underrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned DW = 8;
   localparam int unsigned CW = 3;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t               state;
   logic [SYNC_STAGES-1:0] sclk_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic [SYNC_STAGES-1:0] mosi_sync;
   logic                 sclk_prev;
   logic                 cs_prev;
   logic [DW-1:0]        hold;
   logic [DW-2:0]        tx_sh;
   logic [DW-2:0]        rx_sh;
   logic [CW-1:0]        bit_cnt;

   logic                 sclk_cur_c;
   logic                 cs_cur_c;
   logic                 mosi_cur_c;
   logic                 fall_c;
   logic                 sel_fall_c;
   logic                 sel_rise_c;
   logic                 load_c;
   logic                 done_c;
   logic                 copy_c;
   logic [DW-1:0]        next_byte_c;
   logic [DW-1:0]        rx_byte_c;

   // Equal-depth synchronizers keep sclk, cs_n and mosi aligned; the extra flop feeds edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync <= '0;
         cs_sync   <= '1;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
         cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
         sclk_prev <= sclk_sync[SYNC_STAGES-1];
         cs_prev   <= cs_sync[SYNC_STAGES-1];
      end
   end

   always_comb begin
      sclk_cur_c  = sclk_sync[SYNC_STAGES-1];
      cs_cur_c    = cs_sync[SYNC_STAGES-1];
      mosi_cur_c  = mosi_sync[SYNC_STAGES-1];
      fall_c      = sclk_prev & ~sclk_cur_c;
      sel_fall_c  = cs_prev & ~cs_cur_c;
      sel_rise_c  = ~cs_prev & cs_cur_c;
      load_c      = tx_valid & tx_ready;
      done_c      = (state == SHIFT) & fall_c & (bit_cnt == CW'(0));
      // A byte completing together with deselect does not pull another response byte
      copy_c      = ((state == IDLE) & sel_fall_c) | (done_c & ~sel_rise_c);
      next_byte_c = tx_ready ? TX_IDLE : hold;
      rx_byte_c   = {rx_sh, mosi_cur_c};
   end

   // One-deep holding register; a copy of an empty register leaves a same-cycle load intact
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold     <= '0;
         tx_ready <= 1'b1;
      end else if (copy_c && !tx_ready) begin
         tx_ready <= 1'b1;
      end else if (load_c) begin
         hold     <= tx_data;
         tx_ready <= 1'b0;
      end
   end

   // Frame FSM with shift registers and status pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         busy        <= 1'b0;
         spi_miso    <= 1'b1;
         spi_miso_oe <= 1'b0;
         tx_sh       <= '0;
         rx_sh       <= '0;
         bit_cnt     <= LAST_BIT;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         rx_overrun  <= 1'b0;
         tx_underrun <= 1'b0;
         frame_err   <= 1'b0;
         if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (sel_fall_c) begin
                  state       <= SHIFT;
                  busy        <= 1'b1;
                  spi_miso_oe <= 1'b1;
                  tx_sh       <= next_byte_c[DW-2:0];
                  spi_miso    <= next_byte_c[DW-1];
                  tx_underrun <= tx_ready;
                  bit_cnt     <= LAST_BIT;
               end
            end
            SHIFT: begin
               if (fall_c) begin
                  rx_sh <= rx_byte_c[DW-2:0];
                  if (bit_cnt != CW'(0)) begin
                     bit_cnt  <= bit_cnt - CW'(1);
                     tx_sh    <= {tx_sh[DW-3:0], 1'b0};
                     spi_miso <= tx_sh[DW-2];
                  end else begin
                     rx_data    <= rx_byte_c;
                     rx_valid   <= 1'b1;
                     rx_overrun <= rx_valid & ~rx_ready;
                     bit_cnt    <= LAST_BIT;
                     if (!sel_rise_c) begin
                        tx_sh       <= next_byte_c[DW-2:0];
                        spi_miso    <= next_byte_c[DW-1];
                        tx_underrun <= tx_ready;
                     end
                  end
               end
               if (sel_rise_c) begin
                  state       <= IDLE;
                  busy        <= 1'b0;
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b1;
                  bit_cnt     <= LAST_BIT;
                  // Partial byte left after this cycle's fall (if any) is a framing error
                  frame_err   <= fall_c ? (bit_cnt != CW'(0)) : (bit_cnt != LAST_BIT);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: directed vector table, hand-written corner sequences and random
// frames checked against a byte-level model of the response queue and received bytes.
`timescale 1ns/1ps

module tb_spi_slave;

   localparam int HALF = 6;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       spi_sclk, spi_cs_n, spi_mosi;
   logic       spi_miso, spi_miso_oe;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, rx_ready;
   logic       rx_overrun, tx_underrun, frame_err, busy;

   always #5 clk = ~clk;

   spi_slave dut (
      .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
      .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_overrun(rx_overrun), .tx_underrun(tx_underrun), .frame_err(frame_err),
      .busy(busy)
   );

   int checks = 0;
   int errors = 0;
   int n_under = 0, n_over = 0, n_ferr = 0;
   logic [7:0] tx_q[$];
   logic [7:0] rx_got[$];
   logic [7:0] model_q[$];
   logic [7:0] miso_got[3];
   logic       mid_busy, mid_oe;

   typedef struct {
      int         n;
      logic [7:0] m0, m1;
      int         ntx;
      logic [7:0] t0, t1;
      logic       rdy;
      logic [7:0] e_rx, e_m0, e_m1;
      int         e_under, e_over;
   } vec_t;
   vec_t vt[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic clk_wait(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Response producer: valid/ready driver fed from tx_q
   initial begin
      logic fired;
      fired = 1'b0;
      tx_valid = 1'b0;
      tx_data = '0;
      forever begin
         @(negedge clk);
         if (fired) void'(tx_q.pop_front());
         if (tx_q.size() > 0) begin
            tx_valid = 1'b1;
            tx_data = tx_q[0];
         end else begin
            tx_valid = 1'b0;
         end
         #2;
         fired = rst_n && tx_valid && tx_ready;
      end
   end

   // Consumer and pulse monitor, sampled with settled inputs before the next rising edge
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            if (rx_valid && rx_ready) rx_got.push_back(rx_data);
            if (tx_underrun) n_under++;
            if (rx_overrun) n_over++;
            if (frame_err) n_ferr++;
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // SPI master: mosi on rise, sample on fall; cs_n rises with the last fall unless stopped early
   task automatic spi_xfer(input int nbytes, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input int stop_bits);
      logic [7:0] m[3];
      int total;
      m[0] = b0; m[1] = b1; m[2] = b2;
      total = (stop_bits > 0) ? stop_bits : nbytes * 8;
      spi_cs_n = 1'b0;
      clk_wait(HALF);
      for (int k = 0; k < total; k++) begin
         spi_sclk = 1'b1;
         spi_mosi = m[k/8][7 - (k % 8)];
         clk_wait(HALF);
         spi_sclk = 1'b0;
         miso_got[k/8] = {miso_got[k/8][6:0], spi_miso};
         if (k == 0) begin
            mid_busy = busy;
            mid_oe = spi_miso_oe;
         end
         if (k == total - 1 && stop_bits == 0) spi_cs_n = 1'b1;
         clk_wait(HALF);
      end
      spi_cs_n = 1'b1;
      clk_wait(2 * HALF);
   endtask

   task automatic drain();
      rx_ready = 1'b1;
      clk_wait(4);
      rx_ready = 1'b0;
      clk_wait(1);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_miso"}, spi_miso, 1'b1);
      check({tag, "_oe"}, spi_miso_oe, 1'b0);
      check({tag, "_tx_ready"}, tx_ready, 1'b1);
      check({tag, "_rx_data"}, rx_data, 8'h00);
      check({tag, "_rx_valid"}, rx_valid, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_pulses"}, {rx_overrun, tx_underrun, frame_err}, 3'b000);
   endtask

   initial begin
      int u0, o0, f0;
      rst_n = 1'b0;
      spi_sclk = 1'b0;
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      rx_ready = 1'b0;
      clk_wait(4);
      check_reset_values("reset");
      rst_n = 1'b1;
      clk_wait(4);

      // Directed table: response loaded / underrun / overrun / both bytes consumed
      vt[0] = '{1, 8'h3C, 8'h00, 1, 8'hA5, 8'h00, 1'b0, 8'h3C, 8'hA5, 8'h00, 0, 0};
      vt[1] = '{1, 8'h81, 8'h00, 0, 8'h00, 8'h00, 1'b0, 8'h81, 8'hFF, 8'h00, 1, 0};
      vt[2] = '{2, 8'h11, 8'h22, 0, 8'h00, 8'h00, 1'b0, 8'h22, 8'hFF, 8'hFF, 2, 1};
      vt[3] = '{2, 8'h5A, 8'hE7, 2, 8'h69, 8'hC3, 1'b1, 8'hE7, 8'h69, 8'hC3, 0, 0};
      for (int i = 0; i < 4; i++) begin
         if (vt[i].ntx >= 1) tx_q.push_back(vt[i].t0);
         if (vt[i].ntx >= 2) tx_q.push_back(vt[i].t1);
         clk_wait(4);
         rx_ready = vt[i].rdy;
         u0 = n_under; o0 = n_over;
         spi_xfer(vt[i].n, vt[i].m0, vt[i].m1, 8'h00, 0);
         check($sformatf("vec%0d_rx_data", i), rx_data, vt[i].e_rx);
         check($sformatf("vec%0d_rx_valid", i), rx_valid, !vt[i].rdy);
         check($sformatf("vec%0d_miso0", i), miso_got[0], vt[i].e_m0);
         if (vt[i].n > 1) check($sformatf("vec%0d_miso1", i), miso_got[1], vt[i].e_m1);
         check($sformatf("vec%0d_underrun", i), n_under - u0, vt[i].e_under);
         check($sformatf("vec%0d_overrun", i), n_over - o0, vt[i].e_over);
         check($sformatf("vec%0d_oe_after", i), spi_miso_oe, 1'b0);
         drain();
      end

      // Deselect after 5 bits: framing error, nothing delivered
      u0 = n_under; f0 = n_ferr;
      spi_xfer(1, 8'hF0, 8'h00, 8'h00, 5);
      check("ferr_mid_busy", mid_busy, 1'b1);
      check("ferr_mid_oe", mid_oe, 1'b1);
      check("ferr_pulse", n_ferr - f0, 1);
      check("ferr_rx_valid", rx_valid, 1'b0);
      check("ferr_busy", busy, 1'b0);
      check("ferr_oe", spi_miso_oe, 1'b0);
      check("ferr_underrun", n_under - u0, 1);

      // SCLK toggling while deselected is ignored; the next frame is still byte-aligned
      u0 = n_under; f0 = n_ferr;
      for (int k = 0; k < 10; k++) begin
         spi_sclk = 1'b1; spi_mosi = k[0];
         clk_wait(HALF);
         spi_sclk = 1'b0;
         clk_wait(HALF);
      end
      check("desel_rx_valid", rx_valid, 1'b0);
      check("desel_oe", spi_miso_oe, 1'b0);
      check("desel_busy", busy, 1'b0);
      check("desel_pulses", (n_under - u0) + (n_ferr - f0), 0);
      spi_xfer(1, 8'h96, 8'h00, 8'h00, 0);
      check("desel_next_rx", rx_data, 8'h96);
      check("desel_next_valid", rx_valid, 1'b1);
      drain();

      // Reset after 3 bits of a frame; a fresh frame carries no stale bits
      spi_cs_n = 1'b0;
      clk_wait(HALF);
      for (int k = 0; k < 3; k++) begin
         spi_sclk = 1'b1; spi_mosi = 1'b1;
         clk_wait(HALF);
         spi_sclk = 1'b0;
         clk_wait(HALF);
      end
      rst_n = 1'b0;
      clk_wait(2);
      check_reset_values("midrst");
      spi_cs_n = 1'b1;
      clk_wait(2);
      rst_n = 1'b1;
      clk_wait(HALF);
      f0 = n_ferr;
      spi_xfer(1, 8'hC3, 8'h00, 8'h00, 0);
      check("midrst_rx_data", rx_data, 8'hC3);
      check("midrst_rx_valid", rx_valid, 1'b1);
      check("midrst_miso", miso_got[0], 8'hFF);
      check("midrst_ferr", n_ferr - f0, 0);
      drain();

      // Random frames against the byte-level model
      for (int it = 0; it < 20; it++) begin
         int n, k;
         logic rdy;
         logic [7:0] mb[3];
         logic [7:0] exp_m[3];
         int exp_u;
         n = $urandom_range(1, 3);
         k = $urandom_range(0, 3);
         for (int j = 0; j < 3; j++) mb[j] = 8'($urandom);
         for (int j = 0; j < k; j++) begin
            logic [7:0] b;
            b = 8'($urandom);
            tx_q.push_back(b);
            model_q.push_back(b);
         end
         clk_wait(4);
         exp_u = 0;
         for (int j = 0; j < n; j++) begin
            if (model_q.size() > 0) exp_m[j] = model_q.pop_front();
            else begin
               exp_m[j] = 8'hFF;
               exp_u++;
            end
         end
         rdy = 1'($urandom_range(0, 1));
         rx_ready = rdy;
         rx_got.delete();
         u0 = n_under; o0 = n_over;
         spi_xfer(n, mb[0], mb[1], mb[2], 0);
         for (int j = 0; j < n; j++)
            check($sformatf("rnd%0d_miso%0d", it, j), miso_got[j], exp_m[j]);
         check($sformatf("rnd%0d_underrun", it), n_under - u0, exp_u);
         check($sformatf("rnd%0d_overrun", it), n_over - o0, rdy ? 0 : n - 1);
         check($sformatf("rnd%0d_rx_data", it), rx_data, mb[n-1]);
         check($sformatf("rnd%0d_rx_valid", it), rx_valid, !rdy);
         drain();
         check($sformatf("rnd%0d_got_count", it), rx_got.size(), rdy ? n : 1);
         if (rdy) begin
            for (int j = 0; j < n && j < rx_got.size(); j++)
               check($sformatf("rnd%0d_got%0d", it, j), rx_got[j], mb[j]);
         end else if (rx_got.size() > 0) begin
            check($sformatf("rnd%0d_got_last", it), rx_got[0], mb[n-1]);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
